// File: rtl/gun_flash_pkg.sv
// gun_flash_pkg: shared types for the light-gun flash sequencer.
// Holds the FSM state enum and the frame-counter width helper.
package gun_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    BLACK,
    TARGET,
    COOLDOWN
  } state_t;

  // Wide enough to hold the largest frame count without wrapping.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, async reset to 0.
// Ports: clk, rst (async, active-high), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gun_flash_seq.sv
// gun_flash_seq: light-gun display sequencer (black, target, cooldown).
// Ports: clk, rst (async, active-high), frame_start, shot_req,
//   gun_is_connected, gun_photodetector in; overlay_black,
//   overlay_target, sample_en, busy, seq_done, light_seen, aborted out.
// Option: define GUN_FLASH_AMBIENT_REJECT_EN to reject light seen
//   during the black frames (lamps, bright screen areas).
module gun_flash_seq
  import gun_flash_pkg::*;
#(
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic shot_req,
  input  logic gun_is_connected,
  input  logic gun_photodetector,
  output logic overlay_black,
  output logic overlay_target,
  output logic sample_en,
  output logic busy,
  output logic seq_done,
  output logic light_seen,
  output logic aborted
);

  localparam int CW = cnt_width(
    BLACK_FRAMES, TARGET_FRAMES, COOLDOWN_FRAMES);

  localparam logic [CW-1:0] N_BLACK  = CW'(BLACK_FRAMES);
  localparam logic [CW-1:0] N_TARGET = CW'(TARGET_FRAMES);
  localparam logic [CW-1:0] N_COOL   = CW'(COOLDOWN_FRAMES);

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;

  logic pd_s;
  logic seen;
  logic seen_nx;
  logic done_nx;
  logic abort_nx;
  logic light_nx;
  logic amb;
  logic amb_nx;

  sync_2ff u_pd_sync (
    .clk (clk),
    .rst (rst),
    .d   (gun_photodetector),
    .q   (pd_s)
  );

  // Saturating increment: a counter never wraps back to 0.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    seen_nx  = seen;
    amb_nx   = amb;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    light_nx = light_seen;
    unique case (state)
      IDLE: begin
        if (shot_req && gun_is_connected) begin
          state_nx = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (!gun_is_connected) begin
          state_nx = IDLE;
          abort_nx = 1'b1;
          cnt_nx   = '0;
        end else if (frame_start) begin
          state_nx = BLACK;
          cnt_nx   = '0;
          amb_nx   = 1'b0;
        end
      end
      BLACK: begin
        amb_nx = amb | pd_s;
        if (!gun_is_connected) begin
          state_nx = IDLE;
          abort_nx = 1'b1;
          cnt_nx   = '0;
        end else if (frame_start) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= N_BLACK) begin
            state_nx = TARGET;
            cnt_nx   = '0;
            seen_nx  = 1'b0;
          end
        end
      end
      TARGET: begin
        seen_nx = seen | pd_s;
        if (!gun_is_connected) begin
          state_nx = IDLE;
          abort_nx = 1'b1;
          cnt_nx   = '0;
        end else if (frame_start) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= N_TARGET) begin
            state_nx = COOLDOWN;
            cnt_nx   = '0;
            done_nx  = 1'b1;
`ifdef GUN_FLASH_AMBIENT_REJECT_EN
            light_nx = seen_nx & ~amb;
`else
            light_nx = seen_nx;
`endif
          end
        end
      end
      COOLDOWN: begin
        // A disconnect here is harmless: the verdict is already out.
        if (COOLDOWN_FRAMES == 0) begin
          state_nx = IDLE;
        end else if (frame_start) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= N_COOL) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      seen  <= seen_nx;
    end
  end

`ifdef GUN_FLASH_AMBIENT_REJECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amb <= 1'b0;
    end else begin
      amb <= amb_nx;
    end
  end
`else
  assign amb = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up
  // exactly with the state register while staying registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overlay_black  <= 1'b0;
      overlay_target <= 1'b0;
      sample_en      <= 1'b0;
      busy           <= 1'b0;
      seq_done       <= 1'b0;
      light_seen     <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      overlay_black  <= (state_nx == BLACK);
      overlay_target <= (state_nx == TARGET);
      sample_en      <= (state_nx == TARGET);
      busy           <= (state_nx != IDLE);
      seq_done       <= done_nx;
      light_seen     <= light_nx;
      aborted        <= abort_nx;
    end
  end

endmodule

// File: tb/tb_gun_flash_seq.sv
// tb_gun_flash_seq: self-checking bench for gun_flash_seq.
// Frame pulse every 100 cycles; verdicts checked via scoreboard.
module tb_gun_flash_seq;

  localparam int LIM = 1000;

  logic clk;
  logic rst;
  logic frame_start;
  logic shot_req;
  logic gun_is_connected;
  logic gun_photodetector;
  logic overlay_black;
  logic overlay_target;
  logic sample_en;
  logic busy;
  logic seq_done;
  logic light_seen;
  logic aborted;

  int vectors;
  int miscompares;
  int done_cnt;
  int fcnt;
  logic exp_q[$];

`ifdef GUN_FLASH_AMBIENT_REJECT_EN
  localparam logic AMB_EXP = 1'b0;
`else
  localparam logic AMB_EXP = 1'b1;
`endif

  gun_flash_seq dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .shot_req          (shot_req),
    .gun_is_connected  (gun_is_connected),
    .gun_photodetector (gun_photodetector),
    .overlay_black     (overlay_black),
    .overlay_target    (overlay_target),
    .sample_en         (sample_en),
    .busy              (busy),
    .seq_done          (seq_done),
    .light_seen        (light_seen),
    .aborted           (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    fcnt = 0;
    frame_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fcnt++;
      frame_start = (fcnt % 100 == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each seq_done pops one expected verdict.
  always @(negedge clk) begin
    if (!rst && seq_done) begin
      logic e;
      done_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_seq_done light_seen=%0b", light_seen);
      end else begin
        e = exp_q.pop_front();
        if (light_seen !== e) begin
          miscompares++;
          $display("FAIL verdict got=%0b exp=%0b", light_seen, e);
        end
      end
    end
  end

  task automatic shot();
    @(posedge clk);
    #1 shot_req = 1'b1;
    @(posedge clk);
    #1 shot_req = 1'b0;
  endtask

  task automatic wait_sig(input int sel, input logic val,
                          output int n);
    logic s;
    n = 0;
    while (n < LIM) begin
      @(negedge clk);
      case (sel)
        0: s = busy;
        1: s = overlay_black;
        2: s = overlay_target;
        default: s = seq_done;
      endcase
      if (s === val) break;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({overlay_black, overlay_target, sample_en, busy,
         seq_done, light_seen, aborted} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=0000000",
        {overlay_black, overlay_target, sample_en, busy,
         seq_done, light_seen, aborted});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle busy=%0b exp=0", busy);
    end
  endtask

  task automatic test_basic();
    int n, nb, nt, ns, both, nd, cool;
    bit after;
    nb = 0; nt = 0; ns = 0; both = 0; nd = 0; cool = 0;
    after = 0; n = 0;
    gun_photodetector = 1'b0;
    exp_q.push_back(1'b0);
    shot();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy got=%0b exp=1", busy);
    end
    while (busy === 1'b1 && n < LIM) begin
      if (overlay_black) nb++;
      if (overlay_target) nt++;
      if (sample_en) ns++;
      if (overlay_black && overlay_target) both++;
      if (seq_done) begin nd++; after = 1; end
      if (after) cool++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (nb != 100) begin
      miscompares++;
      $display("FAIL basic_black_cycles got=%0d exp=100", nb);
    end
    vectors++;
    if (nt != 100 || ns != 100) begin
      miscompares++;
      $display("FAIL basic_target_cycles got=%0d/%0d exp=100", nt, ns);
    end
    vectors++;
    if (both != 0 || nd != 1) begin
      miscompares++;
      $display("FAIL basic_overlap_done got=%0d/%0d exp=0/1", both, nd);
    end
    vectors++;
    if (cool != 200) begin
      miscompares++;
      $display("FAIL basic_cooldown_cycles got=%0d exp=200", cool);
    end
  endtask

  task automatic test_same_frame();
    int n;
    exp_q.push_back(1'b0);
    do @(negedge clk); while (fcnt % 100 != 99);
    @(posedge clk);
    #1 shot_req = 1'b1;
    @(posedge clk);
    #1 shot_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || overlay_black !== 1'b0) begin
      miscompares++;
      $display("FAIL same_frame_wait busy=%0b black=%0b exp=1/0",
        busy, overlay_black);
    end
    n = 1;
    while (!overlay_black && n < LIM) begin
      @(negedge clk);
      if (!overlay_black) n++;
    end
    vectors++;
    if (n != 100) begin
      miscompares++;
      $display("FAIL same_frame_delay got=%0d exp=100", n);
    end
    wait_sig(0, 1'b0, n);
  endtask

  task automatic test_hit();
    int n;
    gun_photodetector = 1'b0;
    exp_q.push_back(1'b1);
    shot();
    wait_sig(2, 1'b1, n);
    gun_photodetector = 1'b1;
    wait_sig(2, 1'b0, n);
    gun_photodetector = 1'b0;
    wait_sig(0, 1'b0, n);
    vectors++;
    if (n >= LIM || light_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_held light_seen=%0b n=%0d exp=1", light_seen, n);
    end
  endtask

  task automatic test_ambient();
    int n;
    gun_photodetector = 1'b1;
    exp_q.push_back(AMB_EXP);
    shot();
    wait_sig(0, 1'b0, n);
    gun_photodetector = 1'b0;
    vectors++;
    if (n >= LIM || light_seen !== AMB_EXP) begin
      miscompares++;
      $display("FAIL ambient light_seen=%0b exp=%0b", light_seen, AMB_EXP);
    end
  endtask

  task automatic test_disconnect();
    int n, d0, ones;
    logic prev;
    gun_is_connected = 1'b0;
    shot();
    ones = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) ones++;
    end
    vectors++;
    if (ones != 0) begin
      miscompares++;
      $display("FAIL disc_shot busy_cycles=%0d exp=0", ones);
    end
    gun_is_connected = 1'b1;
    prev = light_seen;
    d0 = done_cnt;
    shot();
    wait_sig(1, 1'b1, n);
    repeat (10) @(posedge clk);
    #1 gun_is_connected = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (aborted !== 1'b1 || busy !== 1'b0 || overlay_black !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pulse abt=%0b busy=%0b blk=%0b exp=1/0/0",
        aborted, busy, overlay_black);
    end
    @(negedge clk);
    vectors++;
    if (aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_one_cycle got=%0b exp=0", aborted);
    end
    gun_is_connected = 1'b1;
    repeat (300) @(negedge clk);
    vectors++;
    if (done_cnt != d0 || light_seen !== prev) begin
      miscompares++;
      $display("FAIL abort_no_done done=%0d exp=%0d ls=%0b exp=%0b",
        done_cnt, d0, light_seen, prev);
    end
  endtask

  task automatic test_back_to_back();
    int n, d0;
    gun_photodetector = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(1'b0);
    shot();
    wait_sig(2, 1'b1, n);
    shot();
    wait_sig(3, 1'b1, n);
    shot();
    wait_sig(0, 1'b0, n);
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_busy done=%0d exp=%0d busy=%0b",
        done_cnt - d0, 1, busy);
    end
    exp_q.push_back(1'b0);
    shot();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_busy got=%0b exp=1", busy);
    end
    wait_sig(0, 1'b0, n);
    vectors++;
    if (done_cnt != d0 + 2) begin
      miscompares++;
      $display("FAIL restart_done got=%0d exp=2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int n, d0;
    gun_photodetector = 1'b0;
    shot();
    wait_sig(2, 1'b1, n);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({overlay_black, overlay_target, sample_en, busy,
         seq_done, light_seen, aborted} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid outputs=%b exp=0000000",
        {overlay_black, overlay_target, sample_en, busy,
         seq_done, light_seen, aborted});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle busy=%0b exp=0", busy);
    end
    d0 = done_cnt;
    exp_q.push_back(1'b0);
    shot();
    wait_sig(2, 1'b1, n);
    wait_sig(0, 1'b0, n);
    vectors++;
    if (n >= LIM || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL reset_mid_rerun done=%0d exp=1", done_cnt - d0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    done_cnt = 0;
    rst = 1'b1;
    shot_req = 1'b0;
    gun_is_connected = 1'b1;
    gun_photodetector = 1'b0;
    test_reset();
    test_basic();
    test_same_frame();
    test_hit();
    test_ambient();
    test_disconnect();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gun_flash_seq.md
Name: gun_flash_seq

Overview:
Generates the display-side half of the light-gun protocol. On a shot request it sequences whole video frames: black frames, then target-highlight frames, then cooldown. During the target frames it samples the synchronised photodetector and reports a latched hit/miss verdict. It sits between trigger capture and the VGA draw pipeline, driving overlay controls to the draw stage.

Parameters:
BLACK_FRAMES, 1, number of full black frames before the target flash (>=1)
TARGET_FRAMES, 1, number of target-highlight frames in which the photodetector is sampled (>=1)
COOLDOWN_FRAMES, 2, frames after the verdict during which new shot requests are ignored (>=0)

Ports:
clk  in  1  pixel clock, 65 MHz
rst  in  1  reset, asynchronous, active-high
frame_start  in  1  one-cycle pulse at the first active pixel of each frame
shot_req  in  1  one-cycle pulse, trigger pressed
gun_is_connected  in  1  level from the gun connection detector
gun_photodetector  in  1  raw asynchronous photodiode level
overlay_black  out  1  draw stage forces the full screen black
overlay_target  out  1  draw stage paints the target white and everything else black
sample_en  out  1  photodetector sampling window is active
busy  out  1  sequence in progress, including cooldown
seq_done  out  1  one-cycle pulse when a verdict is valid
light_seen  out  1  verdict: 1 = hit; held until the next seq_done
aborted  out  1  one-cycle pulse when the sequence is cancelled

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, counters and flags are 0.
- Photodetector passes through a 2-flop synchroniser. Its latency is 2 cycles and it is included in all sampling.
- FSM states: IDLE, WAIT_FRAME, BLACK, TARGET, COOLDOWN. All outputs are registered.
- IDLE:
  - shot_req && gun_is_connected -> WAIT_FRAME.
  - shot_req while disconnected is ignored.
- WAIT_FRAME: on frame_start -> BLACK; frame_cnt cleared.
- BLACK:
  - overlay_black=1.
  - Each frame_start increments frame_cnt.
  - When frame_cnt reaches BLACK_FRAMES on a frame_start -> TARGET, with frame_cnt cleared and seen cleared.
- TARGET:
  - overlay_target=1, sample_en=1.
  - seen |= synced photodetector every cycle.
  - When frame_cnt reaches TARGET_FRAMES on a frame_start -> COOLDOWN.
  - On that transition cycle+1: seq_done=1 and light_seen=seen (ANDed with ambient check, see below).
- COOLDOWN:
  - Overlays are 0 and busy=1.
  - Counts COOLDOWN_FRAMES frame_starts, then -> IDLE.
  - With COOLDOWN_FRAMES=0, goes to IDLE the cycle after seq_done.
- busy=1 in every state except IDLE.
- shot_req while busy is dropped; there is no queueing.
- frame_start and shot_req in the same IDLE cycle: go to WAIT_FRAME only. The sequence waits for the next frame, so a partially drawn frame is never used.
- gun_is_connected falling in WAIT_FRAME, BLACK or TARGET:
  - Next cycle goes to IDLE and pulses aborted.
  - No seq_done; light_seen keeps its old value.
  - A disconnect in COOLDOWN does not abort.
- Frame counters are $clog2(max param + 1) bits wide and saturate, with no wrap.
- Async reset mid-sequence returns to IDLE immediately, with overlays deasserted in the same cycle as reset assertion.

Optional Feature:
GUN_FLASH_AMBIENT_REJECT_EN
- Defined:
  - During BLACK, the synced photodetector ORs into an ambient flag.
  - The verdict is light_seen = seen && !ambient, which rejects aiming at a lamp or bright screen area.
  - ambient is cleared on entry to BLACK.
- Undefined: the ambient flag is absent and light_seen = seen.

Decomposition:
- Package gun_flash_pkg: state enum typedef (IDLE..COOLDOWN) and the frame-counter width function/constant.
- Sub-module sync_2ff (1-bit, async-reset to 0) for the photodetector.
- FSM, counters and verdict register stay in gun_flash_seq.

Test Plan:
Bench uses a frame_start pulse every 100 cycles and default parameters.
- Connected, shot_req, photodetector 0 throughout -> overlay_black for 1 frame, overlay_target for 1 frame, then seq_done with light_seen=0, busy held 2 more frames.
- Connected, photodetector=1 only during TARGET -> seq_done with light_seen=1; photodetector returning to 0 later does not change light_seen.
- Ambient test, macro defined: photodetector=1 for the whole sequence -> light_seen=0. With macro undefined, same stimulus -> light_seen=1.
- Disconnected shot_req -> busy stays 0. Then disconnect mid-BLACK -> aborted pulse, IDLE next cycle, no seq_done.
- Second shot_req during TARGET and during COOLDOWN -> ignored, exactly one seq_done. shot_req after cooldown -> new sequence starts.
- rst asserted during TARGET -> all outputs 0 immediately. After release, FSM is IDLE and the next shot runs a full sequence.
